// File: rtl/ram_port_lsu_pkg.sv
// Shared constants and types for the RAM-port load/store unit.
// Default geometry matches a 32-entry, 32-bit RAM with a one-cycle write delay.
package ram_port_lsu_pkg;

  localparam int LSU_ADDR_WIDTH = 5;
  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_WR_DELAY   = 1;
  localparam int RESP_DEPTH     = 2;
  localparam int CNT_WIDTH      = $clog2(RESP_DEPTH + 1);
  localparam int PTR_WIDTH      = $clog2(RESP_DEPTH);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_LOAD,
    OP_STORE
  } op_e;

endpackage

// File: rtl/ram_port_lsu_if.sv
// Request/response handshake bundle between a datapath (master) and the LSU (slave).
interface ram_port_lsu_if import ram_port_lsu_pkg::*; #(
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/ram_port_lsu_resp_fifo.sv
// Small in-order FIFO buffering load data captured from the RAM until the consumer takes it.
module lsu_resp_fifo import ram_port_lsu_pkg::*; #(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count
);

  logic [DATA_WIDTH-1:0] slots [RESP_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

  assign pop_data = slots[rd_ptr];
  assign count    = count_q;
  assign full     = (count_q == CNT_WIDTH'(RESP_DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/ram_port_lsu.sv
// Load/store front-end for a 1R1W RAM port: hides read latency and delayed write commit,
// stalls loads that would read a not-yet-committed store, and bounds loads by FIFO credits.
module ram_port_lsu import ram_port_lsu_pkg::*; #(
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int WR_DELAY   = LSU_WR_DELAY
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_lsu_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] raddr_0,
  output logic                  ren_0,
  input  logic [DATA_WIDTH-1:0] rdata_0,
  output logic [ADDR_WIDTH-1:0] waddr_0,
  output logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  wen_0,
  output logic                  busy
);

  localparam int TRACK_DEPTH = WR_DELAY + 1;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
  } track_entry_t;

  track_entry_t          track_q [TRACK_DEPTH];
  logic                  load_inflight_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  op_e                   accept_op;
  logic                  raw_hazard;
  logic                  store_pending;
  logic                  credit_stall;
  logic [CNT_WIDTH:0]    credits_used;
  logic [CNT_WIDTH-1:0]  fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Entry i holds a store accepted i+1 edges ago; it commits WR_DELAY-i edges after a load
  // accepted now, so only entries below WR_DELAY can still be invisible to that load's read.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    raw_hazard    = 1'b0;
    store_pending = 1'b0;
    for (int i = 0; i < TRACK_DEPTH; i++) begin
      if (track_q[i].valid) store_pending = 1'b1;
      if (i < WR_DELAY && track_q[i].valid && track_q[i].addr == bus.req_addr) raw_hazard = 1'b1;
    end
  end

  assign credits_used = {1'b0, fifo_count} + {{CNT_WIDTH{1'b0}}, load_inflight_q};
  assign credit_stall = fifo_full || (credits_used >= (CNT_WIDTH + 1)'(RESP_DEPTH));

  assign bus.req_ready = !rst && (bus.req_is_store || (!raw_hazard && !credit_stall));

  always_comb begin
    accept_op = OP_IDLE;
    if (bus.req_valid && bus.req_ready) accept_op = bus.req_is_store ? OP_STORE : OP_LOAD;
  end

  // RAM port is driven straight from the request in the accept cycle, else holds its last value.
  assign ren_0   = (accept_op == OP_LOAD);
  assign wen_0   = (accept_op == OP_STORE);
  assign raddr_0 = ren_0 ? bus.req_addr  : raddr_q;
  assign waddr_0 = wen_0 ? bus.req_addr  : waddr_q;
  assign wdata_0 = wen_0 ? bus.req_wdata : wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TRACK_DEPTH; i++) track_q[i] <= '0;
      load_inflight_q <= 1'b0;
      raddr_q         <= '0;
      waddr_q         <= '0;
      wdata_q         <= '0;
    end else begin
      track_q[0] <= '{valid: wen_0, addr: bus.req_addr};
      for (int i = 1; i < TRACK_DEPTH; i++) track_q[i] <= track_q[i-1];
      load_inflight_q <= ren_0;
      if (ren_0) raddr_q <= bus.req_addr;
      if (wen_0) begin
        waddr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  lsu_resp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (load_inflight_q),
    .push_data (rdata_0),
    .pop       (bus.resp_valid && bus.resp_ready),
    .pop_data  (bus.resp_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.resp_valid = !fifo_empty;
  assign busy           = load_inflight_q || !fifo_empty || store_pending;

endmodule
